// File: rtl/mem_arbiter_pkg.sv
// Shared types and constants for the IF/LSU memory arbiter.
package mem_arbiter_pkg;

  localparam int unsigned WIDTH              = 32;
  localparam int unsigned MASK_W             = WIDTH / 8;
  localparam int unsigned DEF_TIMEOUT_CYCLES = 64;

  typedef enum logic [1:0] {
    ARB_IDLE  = 2'd0,
    ARB_ISSUE = 2'd1,
    ARB_WAIT  = 2'd2,
    ARB_RESP  = 2'd3
  } arb_state_e;

  typedef enum logic {
    OWN_IF  = 1'b0,
    OWN_LSU = 1'b1
  } owner_e;

endpackage

// File: rtl/mem_arbiter_rr_arb2.sv
// Two-input round-robin grant; a tie goes to the requester that did not win last time.
module rr_arb2
  import mem_arbiter_pkg::*;
(
  input  logic   clk,
  input  logic   rst,
  input  logic   req_if,
  input  logic   req_lsu,
  input  logic   update,
  output logic   gnt_valid,
  output owner_e gnt
);

  owner_e last_grant;

  always_comb begin
    gnt_valid = req_if | req_lsu;
    gnt       = OWN_IF;
    if (req_if && req_lsu) begin
      gnt = (last_grant == OWN_IF) ? OWN_LSU : OWN_IF;
    end else if (req_lsu) begin
      gnt = OWN_LSU;
    end
  end

  // Reset to LSU so that IF wins the first tie.
  always_ff @(posedge clk) begin
    if (rst) begin
      last_grant <= OWN_LSU;
    end else if (update && gnt_valid) begin
      last_grant <= gnt;
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// Serialises IF reads and LSU reads/writes onto the single-ported memory, one at a time.
// Define ARB_TIMEOUT_EN to force an error response after TIMEOUT_CYCLES in WAIT.
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES,
  parameter int unsigned TO_CNT_W       = 7
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_req_valid,
  input  logic [WIDTH-1:0]  if_req_addr,
  output logic              if_req_ready,
  output logic              if_resp_valid,
  output logic [WIDTH-1:0]  if_resp_data,
  input  logic              lsu_req_valid,
  input  logic [WIDTH-1:0]  lsu_req_addr,
  input  logic [WIDTH-1:0]  lsu_req_data,
  input  logic [MASK_W-1:0] lsu_req_mask,
  output logic              lsu_req_ready,
  output logic              lsu_resp_valid,
  output logic [WIDTH-1:0]  lsu_resp_data,
  output logic              resp_err,
  output logic              mem_req_valid,
  output logic [WIDTH-1:0]  mem_req_addr,
  output logic [WIDTH-1:0]  mem_req_data,
  output logic [MASK_W-1:0] mem_req_mask,
  input  logic              mem_resp_valid,
  input  logic [WIDTH-1:0]  mem_resp_data
);

  arb_state_e       state;
  owner_e           owner;
  logic             wait_first;
  logic             gnt_valid;
  owner_e           gnt;
  logic             resp_hit;
  logic             timed_out;
  logic [WIDTH-1:0] resp_word;

  rr_arb2 u_rr (
    .clk       (clk),
    .rst       (rst),
    .req_if    (if_req_valid),
    .req_lsu   (lsu_req_valid),
    .update    (state == ARB_IDLE),
    .gnt_valid (gnt_valid),
    .gnt       (gnt)
  );

  assign if_req_ready  = (state == ARB_IDLE) && gnt_valid && (gnt == OWN_IF);
  assign lsu_req_ready = (state == ARB_IDLE) && gnt_valid && (gnt == OWN_LSU);

  // The memory holds resp_valid low for its first busy cycle, so that cycle is skipped.
  assign resp_hit  = !wait_first && mem_resp_valid;
  assign resp_word = resp_hit ? mem_resp_data : '0;

`ifdef ARB_TIMEOUT_EN
  logic [TO_CNT_W-1:0] to_cnt;
  logic                err_q;

  assign timed_out = (to_cnt == TO_CNT_W'(TIMEOUT_CYCLES - 1));
  assign resp_err  = err_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      to_cnt <= '0;
      err_q  <= 1'b0;
    end else begin
      to_cnt <= (state == ARB_WAIT) ? to_cnt + 1'b1 : '0;
      if (state == ARB_WAIT && (resp_hit || timed_out)) begin
        err_q <= !resp_hit;
      end
    end
  end
`else
  logic unused_to_cfg;

  assign unused_to_cfg = ^{TIMEOUT_CYCLES, TO_CNT_W};
  assign timed_out     = 1'b0;
  assign resp_err      = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state          <= ARB_IDLE;
      owner          <= OWN_IF;
      wait_first     <= 1'b0;
      mem_req_valid  <= 1'b0;
      mem_req_addr   <= '0;
      mem_req_data   <= '0;
      mem_req_mask   <= '0;
      if_resp_valid  <= 1'b0;
      if_resp_data   <= '0;
      lsu_resp_valid <= 1'b0;
      lsu_resp_data  <= '0;
    end else begin
      mem_req_valid  <= 1'b0;
      if_resp_valid  <= 1'b0;
      lsu_resp_valid <= 1'b0;
      case (state)
        ARB_IDLE: begin
          if (gnt_valid) begin
            owner         <= gnt;
            mem_req_valid <= 1'b1;
            state         <= ARB_ISSUE;
            if (gnt == OWN_LSU) begin
              mem_req_addr <= lsu_req_addr;
              mem_req_data <= lsu_req_data;
              mem_req_mask <= lsu_req_mask;
            end else begin
              mem_req_addr <= if_req_addr;
              mem_req_data <= '0;
              mem_req_mask <= '0;
            end
          end
        end
        ARB_ISSUE: begin
          wait_first <= 1'b1;
          state      <= ARB_WAIT;
        end
        ARB_WAIT: begin
          wait_first <= 1'b0;
          if (resp_hit || timed_out) begin
            state <= ARB_RESP;
            if (owner == OWN_LSU) begin
              lsu_resp_valid <= 1'b1;
              lsu_resp_data  <= resp_word;
            end else begin
              if_resp_valid <= 1'b1;
              if_resp_data  <= resp_word;
            end
          end
        end
        default: state <= ARB_IDLE;
      endcase
    end
  end

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Two-port arbiter that shares the single-ported unified memory between the instruction-fetch unit (IF, read-only) and the load/store unit (LSU, read/write).
- Sits between the core front/back end and the memory block. Serialises one transaction at a time using round-robin priority.
- Drives the memory's valid/addr/data/mask request interface and collects its response.

Parameters:
- TIMEOUT_CYCLES, 64: maximum WAIT cycles before a forced error response. Used only with ARB_TIMEOUT_EN.
- TO_CNT_W, 7: width of the timeout counter. Must satisfy 2^TO_CNT_W > TIMEOUT_CYCLES.

Ports:
- clk  in  1  clock; all logic is on the rising edge
- rst  in  1  synchronous, active-high reset
- if_req_valid  in  1  IF requests a read; held until if_req_ready
- if_req_addr  in  `WIDTH  IF byte address
- if_req_ready  out  1  IF request accepted this cycle
- if_resp_valid  out  1  one-cycle pulse; if_resp_data is valid
- if_resp_data  out  `WIDTH  read data
- lsu_req_valid  in  1  LSU request; held until lsu_req_ready
- lsu_req_addr  in  `WIDTH  LSU byte address
- lsu_req_data  in  `WIDTH  store data
- lsu_req_mask  in  `WIDTH/8  byte write mask; 0 means read
- lsu_req_ready  out  1  LSU request accepted this cycle
- lsu_resp_valid  out  1  one-cycle pulse
- lsu_resp_data  out  `WIDTH  read data (also returned on stores)
- resp_err  out  1  qualifies either resp_valid; 1 = timed out
- mem_req_valid  out  1  to memory; one-cycle pulse
- mem_req_addr  out  `WIDTH  to memory
- mem_req_data  out  `WIDTH  to memory
- mem_req_mask  out  `WIDTH/8  to memory; forced to 0 for IF
- mem_resp_valid  in  1  from memory
- mem_resp_data  in  `WIDTH  from memory

Behaviour:
- Reset:
  - state=IDLE, last_grant=LSU, so IF wins the first tie.
  - All ready, valid and resp_err outputs are 0.
  - Data and address registers are 0.
- States: IDLE, ISSUE, WAIT, RESP. Encoding is localparam, 2 bits.
- IDLE:
  - Grant logic: if only one requester is valid, grant it. If both are valid, grant the one not equal to last_grant.
  - The granted requester's ready is asserted combinationally, only in IDLE.
  - On that edge: latch addr/data/mask and owner, update last_grant, go to ISSUE.
  - With no valid request, stay in IDLE.
- ISSUE:
  - mem_req_valid=1 for exactly this cycle, carrying the latched payload. Go to WAIT.
  - mem_req_addr/data/mask hold the latched values in all states.
- WAIT:
  - mem_resp_valid is ignored in the first WAIT cycle, because the memory deasserts it for at least one cycle while busy.
  - From the second WAIT cycle on, mem_resp_valid=1 latches mem_resp_data into the owner's resp_data register, sets resp_err=0, and moves to RESP.
- RESP:
  - The owner's resp_valid=1 for exactly one cycle; the other requester's resp_valid stays 0. Go to IDLE.
  - resp_data holds its value until the next response.
- Minimum latency: ready at cycle N, resp_valid at cycle N+4. No new grant before RESP completes: one outstanding transaction only.
- The non-granted requester keeps its valid asserted. It is guaranteed the next grant, so there is no starvation.
- A requester dropping valid before ready is legal and nothing is latched. Changing the payload while valid is high and ready is low is illegal (protocol error, not checked).
- Reset mid-transaction aborts it:
  - no resp_valid is issued;
  - the outstanding memory op is not cancelled and its response is discarded;
  - the state returns to IDLE.
- Address passes through unmodified as a byte address; the memory performs word indexing.
- Masks are 4 bits for a 32-bit WIDTH.

Optional Feature:
- Macro ARB_TIMEOUT_EN.
- Defined:
  - A TO_CNT_W counter clears on entry to WAIT and increments each WAIT cycle.
  - On reaching TIMEOUT_CYCLES with no response, go to RESP with resp_err=1 and resp_data=0.
  - A late memory response arriving after that is discarded.
- Undefined:
  - No counter. WAIT lasts until mem_resp_valid.
  - resp_err is tied to 0.

Decomposition:
- Package (common.vh additions):
  - state localparams ARB_IDLE/ISSUE/WAIT/RESP;
  - owner encoding OWN_IF=0, OWN_LSU=1;
  - default TIMEOUT_CYCLES.
- Sub-module rr_arb2: a 2-input round-robin grant with last_grant register, update enable and reset. Everything else is the FSM in mem_arbiter.

Test Plan:
- Single IF read: if_req_valid, addr=0x8. Expect if_req_ready at cycle 0, mem_req_valid at cycle 1 with mask=0, and if_resp_valid at cycle 4 with data = model word[2]. lsu_resp_valid stays 0 throughout.
- LSU store then load: addr=0x10, data=0xDEADBEEF, mask=0xF, then a read of 0x10. Expect the second lsu_resp_data = 0xDEADBEEF, and mem_req_mask=0xF on the first issue only.
- Contention: both valid continuously for 4 transactions. Grant order must be IF, LSU, IF, LSU, and no if_req_ready and lsu_req_ready ever in the same cycle.
- Slow memory: memory model delays mem_resp_valid by 10 cycles. Expect resp_valid at exactly 1 cycle after the response, and no second mem_req_valid while in WAIT.
- Reset in WAIT: assert rst for 1 cycle during an LSU read. Expect no lsu_resp_valid, state IDLE, and the next IF request served normally with if_req_ready on the first idle cycle.
- With ARB_TIMEOUT_EN and TIMEOUT_CYCLES=8, memory never responds. Expect lsu_resp_valid with resp_err=1 and data=0 eight WAIT cycles after entry, then the arbiter accepts new requests.
